// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage core.
// Resolves, in priority order: EX redirects, multi-cycle MDU ops, load-use
// hazards and instruction-memory wait states. The stall, flush and redirect
// controls are combinational and take effect in the same cycle. Saturating
// perf counters track stall cycles and redirect-caused flushes.
//
// Ports:
//   clk, rst          core clock; asynchronous active-low reset
//   id_rs1/id_rs2     source indices of the ID instruction, with use flags
//   ex_rd/ex_mem_read destination and load flag of the EX instruction
//   ex_redirect(_pc)  taken branch/jump resolved in EX, and its target
//   mdu_start/done    multi-cycle mul/div launch and completion
//   imem_ready        fetch data returned this cycle
//   pc_*, if_id_*, id_ex_*  stall/flush/redirect controls
//   stall_cycles      cycles with pc_stall=1
//   flush_count       redirect-caused IF/ID flush cycles
module hazard_ctrl #(
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic [31:0]       ex_redirect_pc,
  input  logic              mdu_start,
  input  logic              mdu_done,
  input  logic              imem_ready,
  output logic              pc_stall,
  output logic              pc_redirect,
  output logic [31:0]       redirect_pc,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  localparam int unsigned PC_W = 32;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MDU_BUSY   = 2'd1,
    FETCH_WAIT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            drop_next, drop_next_nxt;
  logic [PC_W-1:0] pend_pc, pend_pc_nxt;

  logic            lu;
  logic            pc_stall_raw, pc_redirect_raw;
  logic            if_id_stall_raw, if_id_flush_raw;
  logic            id_ex_stall_raw, id_ex_flush_raw;
  logic [PC_W-1:0] redirect_pc_raw;
  logic            flush_inc;

  // Load-use hazard: ID reads the register the EX load is about to write.
  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

  // State register and pending-redirect holding registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drop_next <= 1'b0;
      pend_pc   <= '0;
    end else begin
      state     <= state_nxt;
      drop_next <= drop_next_nxt;
      pend_pc   <= pend_pc_nxt;
    end
  end

  // Next-state and raw control decode.
  always_comb begin
    state_nxt       = state;
    drop_next_nxt   = drop_next;
    pend_pc_nxt     = pend_pc;
    pc_stall_raw    = 1'b0;
    pc_redirect_raw = 1'b0;
    if_id_stall_raw = 1'b0;
    if_id_flush_raw = 1'b0;
    id_ex_stall_raw = 1'b0;
    id_ex_flush_raw = 1'b0;
    redirect_pc_raw = '0;
    flush_inc       = 1'b0;

    unique case (state)
      RUN: begin
        if (ex_redirect) begin
          pc_redirect_raw = 1'b1;
          redirect_pc_raw = ex_redirect_pc;
          if_id_flush_raw = 1'b1;
          id_ex_flush_raw = 1'b1;
          flush_inc       = 1'b1;
          // Fetch for the target cannot start yet; replay it when imem returns.
          if (!imem_ready) begin
            drop_next_nxt = 1'b1;
            pend_pc_nxt   = ex_redirect_pc;
            state_nxt     = FETCH_WAIT;
          end
        end else if (mdu_start && !mdu_done) begin
          pc_stall_raw    = 1'b1;
          if_id_stall_raw = 1'b1;
          id_ex_stall_raw = 1'b1;
          state_nxt       = MDU_BUSY;
        end else if (lu) begin
          pc_stall_raw    = 1'b1;
          if_id_stall_raw = 1'b1;
          id_ex_flush_raw = 1'b1;
        end else if (!imem_ready) begin
          pc_stall_raw    = 1'b1;
          if_id_flush_raw = 1'b1;
          state_nxt       = FETCH_WAIT;
        end
      end

      // EX holds the MDU op, so redirects and load-use cannot originate here.
      MDU_BUSY: begin
        if (mdu_done) begin
          state_nxt = RUN;
        end else begin
          pc_stall_raw    = 1'b1;
          if_id_stall_raw = 1'b1;
          id_ex_stall_raw = 1'b1;
        end
      end

      FETCH_WAIT: begin
        if (!imem_ready) begin
          pc_stall_raw    = 1'b1;
          if_id_flush_raw = 1'b1;
          // Latest redirect wins; it is replayed once the fetch completes.
          if (ex_redirect) begin
            drop_next_nxt   = 1'b1;
            pend_pc_nxt     = ex_redirect_pc;
            id_ex_flush_raw = 1'b1;
          end
        end else begin
          state_nxt     = RUN;
          drop_next_nxt = 1'b0;
          if (ex_redirect) begin
            // Redirect arriving on the return cycle supersedes any pending one.
            if_id_flush_raw = 1'b1;
            id_ex_flush_raw = 1'b1;
            pc_redirect_raw = 1'b1;
            redirect_pc_raw = ex_redirect_pc;
            flush_inc       = 1'b1;
          end else if (drop_next) begin
            if_id_flush_raw = 1'b1;
            pc_redirect_raw = 1'b1;
            redirect_pc_raw = pend_pc;
            flush_inc       = 1'b1;
          end
        end
      end

      default: begin
        state_nxt     = RUN;
        drop_next_nxt = 1'b0;
      end
    endcase
  end

  // Outputs forced low during reset; flush overrides stall on the same register.
  assign pc_stall    = rst & pc_stall_raw;
  assign pc_redirect = rst & pc_redirect_raw;
  assign redirect_pc = (rst && pc_redirect_raw) ? redirect_pc_raw : PC_W'(0);
  assign if_id_flush = rst & if_id_flush_raw;
  assign if_id_stall = rst & if_id_stall_raw & ~if_id_flush_raw;
  assign id_ex_flush = rst & id_ex_flush_raw;
  assign id_ex_stall = rst & id_ex_stall_raw & ~id_ex_flush_raw;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pc_stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + PERF_W'(1);
      end
      if (flush_inc && (flush_count != '1)) begin
        flush_count <= flush_count + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Control vector order: {pc_stall, pc_redirect, if_id_stall, if_id_flush,
// id_ex_stall, id_ex_flush}.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read;
  logic        ex_redirect, mdu_start, mdu_done, imem_ready;
  logic [31:0] ex_redirect_pc;

  logic        pc_stall, pc_redirect, if_id_stall, if_id_flush;
  logic        id_ex_stall, id_ex_flush;
  logic [31:0] redirect_pc, stall_cycles, flush_count;

  logic        s_pc_stall, s_pc_redirect, s_if_id_stall, s_if_id_flush;
  logic        s_id_ex_stall, s_id_ex_flush;
  logic [31:0] s_redirect_pc;
  logic [2:0]  s_stall_cycles, s_flush_count;

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .imem_ready(imem_ready),
    .pc_stall(pc_stall), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Narrow-counter instance used only to observe saturation.
  hazard_ctrl #(.PERF_W(3)) u_sat (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .imem_ready(imem_ready),
    .pc_stall(s_pc_stall), .pc_redirect(s_pc_redirect), .redirect_pc(s_redirect_pc),
    .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
    .id_ex_stall(s_id_ex_stall), .id_ex_flush(s_id_ex_flush),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic [5:0] exp);
    chk(tag, 32'({pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush}),
        32'(exp));
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = 32'h0;
    mdu_start = 1'b0; mdu_done = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  // Advance to the next falling edge, where new inputs are applied.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #1;
    ctl("reset_ctl", 6'b000000);
    chk("reset_rpc", redirect_pc, 32'h0);
    chk("reset_stall_cnt", stall_cycles, 32'd0);
    chk("reset_flush_cnt", flush_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Load-use hazard: one-cycle stall with ID/EX bubble.
    set_lu(5'd5); #1;
    ctl("lu_ctl", 6'b101001);
    step();
    chk("lu_stall_cnt", stall_cycles, 32'd1);
    idle(); #1;
    ctl("lu_after", 6'b000000);
    step();
    set_lu(5'd0); #1;
    ctl("lu_x0_ctl", 6'b000000);
    step();
    chk("lu_x0_stall_cnt", stall_cycles, 32'd1);

    // RUN redirect with fetch ready.
    idle(); ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_0100; #1;
    ctl("redir_ctl", 6'b010101);
    chk("redir_rpc", redirect_pc, 32'h0000_0100);
    step();
    chk("redir_flush_cnt", flush_count, 32'd1);
    idle(); #1;
    ctl("redir_after", 6'b000000);
    step();

    // MDU: start, three busy cycles (redirect+lu mid-busy ignored), done.
    mdu_start = 1'b1; #1;
    ctl("mdu_c0", 6'b101010);
    step();
    mdu_start = 1'b0; #1;
    ctl("mdu_c1", 6'b101010);
    step();
    ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_0300; set_lu(5'd5); #1;
    ctl("mdu_c2_redir_ignored", 6'b101010);
    step();
    idle(); #1;
    ctl("mdu_c3", 6'b101010);
    step();
    mdu_done = 1'b1; #1;
    ctl("mdu_done_ctl", 6'b000000);
    step();
    chk("mdu_stall_cnt", stall_cycles, 32'd5);
    chk("mdu_flush_cnt", flush_count, 32'd1);

    // Fetch wait with redirect in its second cycle.
    idle(); imem_ready = 1'b0; #1;
    ctl("fw_c1", 6'b100100);
    step();
    ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_0200; #1;
    ctl("fw_c2_redir", 6'b100101);
    step();
    ex_redirect = 1'b0; #1;
    ctl("fw_c3", 6'b100100);
    step();
    imem_ready = 1'b1; #1;
    ctl("fw_ready_ctl", 6'b010100);
    chk("fw_ready_rpc", redirect_pc, 32'h0000_0200);
    step();
    chk("fw_stall_cnt", stall_cycles, 32'd8);
    chk("fw_flush_cnt", flush_count, 32'd2);
    #1;
    ctl("fw_back_run", 6'b000000);
    step();
    set_lu(5'd5); #1;
    ctl("fw_run_lu", 6'b101001);
    step();

    // Priority: redirect + load-use + fetch wait together.
    idle(); set_lu(5'd5); ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_0400;
    imem_ready = 1'b0; #1;
    ctl("prio_ctl", 6'b010101);
    chk("prio_rpc", redirect_pc, 32'h0000_0400);
    step();
    chk("prio_flush_cnt", flush_count, 32'd3);
    idle(); imem_ready = 1'b0; #1;
    ctl("prio_wait", 6'b100100);
    step();
    imem_ready = 1'b1; #1;
    ctl("prio_drop_ctl", 6'b010100);
    chk("prio_drop_rpc", redirect_pc, 32'h0000_0400);
    step();
    chk("prio_stall_cnt", stall_cycles, 32'd10);
    chk("prio_flush_cnt2", flush_count, 32'd4);
    chk("sat_stall_cnt", 32'(s_stall_cycles), 32'd7);
    chk("sat_flush_cnt", 32'(s_flush_count), 32'd4);

    // Asynchronous reset in the middle of MDU_BUSY.
    mdu_start = 1'b1; #1;
    step();
    mdu_start = 1'b0; #1;
    ctl("rst_pre_busy", 6'b101010);
    #2 rst = 1'b0;
    #1;
    ctl("rst_async_ctl", 6'b000000);
    chk("rst_async_stall_cnt", stall_cycles, 32'd0);
    chk("rst_async_flush_cnt", flush_count, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; #1;
    ctl("rst_release_run", 6'b000000);
    step();
    chk("rst_release_stall_cnt", stall_cycles, 32'd0);
    chk("rst_release_flush_cnt", flush_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
